// File: rtl/enc_binder_bank.sv
// Hypervector binder bank: rotates NUM_FEAT level hypervectors by a per-feature
// shift (base + i*stride), LANES features per cycle, left to bind and right to unbind.
//
// state | meaning
// IDLE  | waiting for start_encoding; parameters latched on accept
// RUN   | one group of LANES features rotated and written per edge
// DONE  | single-cycle done pulse, then back to IDLE
module enc_binder_bank #(
    parameter int HV_DIM   = 1024,
    parameter int NUM_FEAT = 16,
    parameter int LANES    = 4
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          start_encoding,
    input  logic                          unbind,
    input  logic [$clog2(HV_DIM)-1:0]     shift_base,
    input  logic [$clog2(HV_DIM)-1:0]     shift_stride,
    input  logic [HV_DIM-1:0]             level_hv   [NUM_FEAT],
    output logic [HV_DIM-1:0]             shifted_hv [NUM_FEAT],
    output logic                          busy,
    output logic                          done
);
    localparam int SHIFT_W = $clog2(HV_DIM);
    localparam int NUM_GRP = (NUM_FEAT + LANES - 1) / LANES;
    localparam int GRP_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
    localparam int PAD_N   = NUM_GRP * LANES;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [GRP_W-1:0]    grp;
    logic                unbind_q;
    logic [SHIFT_W-1:0]  stride_q;
    logic [SHIFT_W-1:0]  run_shift;
    logic [SHIFT_W-1:0]  stride_lanes;

    logic [HV_DIM-1:0]   level_pad [PAD_N];
    logic [HV_DIM-1:0]   lane_in   [LANES];
    logic [HV_DIM-1:0]   lane_out  [LANES];
    logic [SHIFT_W-1:0]  lane_shift[LANES];

    // Doubled-vector rotate: the upper half of a left shift (or lower half of a
    // right shift) is the rotation, and s = 0 falls out as an identity copy.
    function automatic logic [HV_DIM-1:0] rotate(input logic [HV_DIM-1:0] x,
                                                 input logic [SHIFT_W-1:0] s,
                                                 input logic right);
        logic [2*HV_DIM-1:0] d;
        d = {x, x};
        if (right) begin
            d = d >> s;
            return d[HV_DIM-1:0];
        end
        d = d << s;
        return d[2*HV_DIM-1:HV_DIM];
    endfunction

    // Padding lanes past NUM_FEAT read zeros; their results are never stored.
    for (genvar k = 0; k < PAD_N; k++) begin : g_pad
        if (k < NUM_FEAT) begin : g_real
            assign level_pad[k] = level_hv[k];
        end else begin : g_zero
            assign level_pad[k] = '0;
        end
    end

    assign stride_lanes = SHIFT_W'(LANES) * stride_q;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = '0;
            for (int g = 0; g < NUM_GRP; g++) begin
                if (grp == GRP_W'(g)) lane_in[l] = level_pad[g*LANES + l];
            end
            lane_shift[l] = run_shift + SHIFT_W'(l) * stride_q;
            lane_out[l]   = rotate(lane_in[l], lane_shift[l], unbind_q);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            grp       <= '0;
            unbind_q  <= 1'b0;
            stride_q  <= '0;
            run_shift <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start_encoding) begin
                        state     <= RUN;
                        grp       <= '0;
                        unbind_q  <= unbind;
                        stride_q  <= shift_stride;
                        run_shift <= shift_base;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    grp       <= grp + 1'b1;
                    run_shift <= run_shift + stride_lanes;
                    if (grp == GRP_W'(NUM_GRP - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shifted_hv <= '{default: '0};
        end else if (state == RUN) begin
            for (int i = 0; i < NUM_FEAT; i++) begin
                if (grp == GRP_W'(i / LANES)) shifted_hv[i] <= lane_out[i % LANES];
            end
        end
    end
endmodule
